// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: load handshake plus serial line outputs for serial_frame_tx.
//   load_valid  word on load_data is offered this cycle (master -> slave)
//   load_ready  transmitter idle, can accept a word   (slave -> master)
//   load_data   WIDTH-bit word to transmit            (master -> slave)
//   sout        registered serial line, idles high    (slave -> master)
//   busy        frame on the line, START through STOP (slave -> master)
//   done        one-cycle pulse after the stop bit    (slave -> master)
interface serial_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data,
    input  load_ready, sout, busy, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, sout, busy, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter.
// A word accepted on the valid/ready handshake is sent as a start bit (0),
// WIDTH data bits and a stop bit (1); every bit is held CLKS_PER_BIT clocks.
// Ports:
//   clk  system clock, all state changes on posedge
//   rst  synchronous active-high reset
//   bus  serial_frame_tx_if.slave: load_valid/load_ready/load_data in,
//        sout/busy/done out
// Parameters: WIDTH (data bits, >=1), CLKS_PER_BIT (>=1),
//   LSB_FIRST (1: bit 0 first, 0: bit WIDTH-1 first).
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int LSB_FIRST    = 1
) (
  input logic              clk,
  input logic              rst,
  serial_frame_tx_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "serial_frame_tx: WIDTH must be >= 1");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $fatal(1, "serial_frame_tx: CLKS_PER_BIT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    clk_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_next;
  logic             tx_line;
  logic             tx_busy;
  logic             tx_done;
  logic             bit_end;
  logic             first_bit;
  logic             next_bit;

  assign bit_end = (clk_cnt == CLK_LAST);

  // The bit on the line is always the outgoing end of the shift register;
  // next_bit is what that end will hold once the current bit is shifted out.
  always_comb begin
    shift_next = shreg;
    first_bit  = 1'b0;
    next_bit   = 1'b0;
    if (LSB_FIRST != 0) begin
      shift_next = shreg >> 1;
      first_bit  = shreg[0];
      next_bit   = shift_next[0];
    end else begin
      shift_next = shreg << 1;
      first_bit  = shreg[WIDTH-1];
      next_bit   = shift_next[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_line <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          // load_ready is exactly (state == IDLE), so valid alone completes
          // the handshake here; valid in any other state is ignored.
          if (bus.load_valid) begin
            shreg   <= bus.load_data;
            state   <= START;
            tx_line <= 1'b0;
            tx_busy <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= DATA;
            tx_line <= first_bit;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            shreg   <= shift_next;
            // bit_cnt stops at WIDTH-1; the last bit leads straight to STOP.
            if (bit_cnt == BIT_LAST) begin
              state   <= STOP;
              tx_line <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_line <= next_bit;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_line <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.sout       = tx_line;
  assign bus.busy       = tx_busy;
  assign bus.done       = tx_done;

  // State invariants, evaluated on the register values present at each edge.
  always @(posedge clk) begin
    if (!rst) begin
      assert final ((state != IDLE) || (tx_line && !tx_busy))
        $info("idle line ok");
      else $error("idle line/busy wrong at %0t", $time);
      assert final ((state != START) || !tx_line)
        $info("start bit ok");
      else $error("start bit not low at %0t", $time);
      assert final ((state != STOP) || tx_line)
        $info("stop bit ok");
      else $error("stop bit not high at %0t", $time);
      assert final ((state == IDLE) == !tx_busy)
        $info("ready/busy ok");
      else $error("load_ready != !busy at %0t", $time);
      assert final (int'(bit_cnt) < WIDTH)
        $info("bit_cnt ok");
      else $error("bit_cnt out of range at %0t", $time);
      assert final (!tx_done || (state == IDLE))
        $info("done ok");
      else $error("done outside IDLE at %0t", $time);
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: drives two transmitters (CPB=1 LSB-first, CPB=4
// MSB-first) and compares every line cycle against the bit a frame of
// start/data/stop must carry at that cycle offset.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  logic       rst_v [2];
  logic       lv    [2];
  logic [7:0] ld    [2];
  logic       so    [2];
  logic       bz    [2];
  logic       dn    [2];
  logic       rdy   [2];

  serial_frame_tx_if #(.WIDTH(8)) if_a ();
  serial_frame_tx_if #(.WIDTH(8)) if_b ();

  assign if_a.load_valid = lv[0];
  assign if_a.load_data  = ld[0];
  assign if_b.load_valid = lv[1];
  assign if_b.load_data  = ld[1];
  assign so[0]  = if_a.sout;
  assign bz[0]  = if_a.busy;
  assign dn[0]  = if_a.done;
  assign rdy[0] = if_a.load_ready;
  assign so[1]  = if_b.sout;
  assign bz[1]  = if_b.busy;
  assign dn[1]  = if_b.done;
  assign rdy[1] = if_b.load_ready;

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1)) dut_a (
    .clk (clk),
    .rst (rst_v[0]),
    .bus (if_a)
  );

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(0)) dut_b (
    .clk (clk),
    .rst (rst_v[1]),
    .bus (if_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Line value k cycles into a frame: slot 0 start, slots 1..8 data, 9 stop.
  function automatic logic exp_bit(input logic [7:0] data, input int k,
                                   input int cpb, input int lsb);
    int idx;
    idx = k / cpb;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return (lsb != 0) ? data[idx-1] : data[8-idx];
  endfunction

  // Offers a word, checks every frame cycle and the done cycle. inj_at >= 0
  // pulses load_valid with 8'hFF at that frame cycle; abort_at >= 0 resets
  // the transmitter at that frame cycle instead of finishing the frame.
  task automatic send_frame(input int d, input logic [7:0] data, input bit hold,
                            input int inj_at, input int abort_at, output int start_c);
    int  cpb, lsb, f;
    bit  got;
    cpb = (d != 0) ? 4 : 1;
    lsb = (d != 0) ? 0 : 1;
    f   = 10 * cpb;
    start_c = -1;
    ld[d] = data;
    lv[d] = 1'b1;
    got   = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (rdy[d]) got = 1'b1;
      @(posedge clk); #1;
    end
    if (!got) begin
      chk($sformatf("accept_timeout d%0d", d), 32'd0, 32'd1);
      lv[d] = 1'b0;
      return;
    end
    start_c = cyc;
    if (!hold) lv[d] = 1'b0;
    for (int k = 0; k < f; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("sout d%0d %02h k%0d", d, data, k), 32'(so[d]), 32'(exp_bit(data, k, cpb, lsb)));
      chk($sformatf("busy d%0d k%0d", d, k), 32'(bz[d]), 32'd1);
      chk($sformatf("ready d%0d k%0d", d, k), 32'(rdy[d]), 32'd0);
      chk($sformatf("done d%0d k%0d", d, k), 32'(dn[d]), 32'd0);
      if (k == inj_at) begin
        ld[d] = 8'hFF;
        lv[d] = 1'b1;
      end
      if (inj_at >= 0 && k == inj_at + 1) lv[d] = 1'b0;
      if (k == abort_at) begin
        rst_v[d] = 1'b1;
        @(posedge clk); #1;
        rst_v[d] = 1'b0;
        chk($sformatf("abort sout d%0d", d), 32'(so[d]), 32'd1);
        chk($sformatf("abort busy d%0d", d), 32'(bz[d]), 32'd0);
        chk($sformatf("abort ready d%0d", d), 32'(rdy[d]), 32'd1);
        chk($sformatf("abort done d%0d", d), 32'(dn[d]), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("abort done+1 d%0d", d), 32'(dn[d]), 32'd0);
        chk($sformatf("abort sout+1 d%0d", d), 32'(so[d]), 32'd1);
        return;
      end
    end
    @(posedge clk); #1;
    chk($sformatf("done pulse d%0d %02h", d, data), 32'(dn[d]), 32'd1);
    chk($sformatf("done ready d%0d", d), 32'(rdy[d]), 32'd1);
    chk($sformatf("done busy d%0d", d), 32'(bz[d]), 32'd0);
    chk($sformatf("done sout d%0d", d), 32'(so[d]), 32'd1);
  endtask

  task automatic idle(input int d, input int n);
    lv[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle done d%0d", d), 32'(dn[d]), 32'd0);
      chk($sformatf("idle busy d%0d", d), 32'(bz[d]), 32'd0);
      chk($sformatf("idle sout d%0d", d), 32'(so[d]), 32'd1);
      chk($sformatf("idle ready d%0d", d), 32'(rdy[d]), 32'd1);
    end
  endtask

  initial begin
    int s1, s2, d, inj, f;
    logic [7:0] w;
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    lv[0] = 1'b0;    lv[1] = 1'b0;
    ld[0] = 8'h00;   ld[1] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset sout d%0d", i), 32'(so[i]), 32'd1);
      chk($sformatf("reset busy d%0d", i), 32'(bz[i]), 32'd0);
      chk($sformatf("reset done d%0d", i), 32'(dn[i]), 32'd0);
      chk($sformatf("reset ready d%0d", i), 32'(rdy[i]), 32'd1);
    end

    send_frame(0, 8'hA5, 1'b0, -1, -1, s1);
    idle(0, 2);
    send_frame(1, 8'h81, 1'b0, -1, -1, s1);
    idle(1, 2);

    send_frame(0, 8'h3C, 1'b1, -1, -1, s1);
    send_frame(0, 8'hC3, 1'b0, -1, -1, s2);
    chk("b2b start gap", 32'(s2 - s1), 32'd11);
    idle(0, 2);

    send_frame(0, 8'h00, 1'b0, 4, -1, s1);
    idle(0, 15);

    send_frame(0, 8'h5A, 1'b0, -1, 4, s1);
    send_frame(0, 8'h55, 1'b0, -1, -1, s1);
    idle(0, 1);

    send_frame(1, 8'h96, 1'b0, -1, 16, s1);
    send_frame(1, 8'h55, 1'b0, -1, -1, s1);
    idle(1, 1);

    for (int i = 0; i < 40; i++) begin
      d   = int'($urandom_range(0, 1));
      w   = 8'($urandom);
      f   = (d != 0) ? 40 : 10;
      inj = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, f - 2)) : -1;
      send_frame(d, w, 1'b0, inj, -1, s1);
      idle(d, int'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
